// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch front-panel controller and its surroundings.
// The master side drives the raw buttons and the overflow flag. The slave side is the controller.
interface stopwatch_ctrl_if #(
    parameter int unsigned LAP_W = 4
);
    logic             btn_start_stop_n;
    logic             btn_lap_reset_n;
    logic             stopwatch_overflow;
    logic             sw_start_stop;
    logic             sw_hold;
    logic             sw_reset_n;
    logic             running;
    logic [LAP_W-1:0] lap_count;
    logic             ovf_flag;

    modport master (
        output btn_start_stop_n, btn_lap_reset_n, stopwatch_overflow,
        input  sw_start_stop, sw_hold, sw_reset_n, running, lap_count, ovf_flag
    );

    modport slave (
        input  btn_start_stop_n, btn_lap_reset_n, stopwatch_overflow,
        output sw_start_stop, sw_hold, sw_reset_n, running, lap_count, ovf_flag
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller for the 100 Hz stopwatch datapath.
// It synchronises and debounces the two buttons, runs the user-mode FSM, and drives the datapath strobes.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned LAP_W          = 4
) (
    input  logic            CLK_100Hz,
    input  logic            reset_n,
    stopwatch_ctrl_if.slave bus
);
    localparam int unsigned      CNT_W   = 4;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [LAP_W-1:0] LAP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUNNING,
        S_LAP,
        S_STOPPED,
        S_OVF,
        S_CLEAR
    } state_t;

    // Bit 0 is START/STOP. Bit 1 is LAP/RESET.
    logic [1:0]            w_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_db;
    logic [1:0][CNT_W-1:0] r_cnt;
    logic [1:0]            r_evt;

    state_t           r_state;
    logic             r_start_stop;
    logic             r_hold;
    logic [LAP_W-1:0] r_lap_count;
    logic             r_running;
    logic             r_ovf;
    logic             r_clr_n;
    logic             r_clr_cnt;

    logic w_start;
    logic w_lap;
    logic w_ovf;

    assign w_raw = {bus.btn_lap_reset_n, bus.btn_start_stop_n};

    // The debounced state resets to "pressed", so a button held through reset gives no event.
    always_ff @(posedge CLK_100Hz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '0;
            r_cnt   <= '0;
            r_evt   <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int unsigned b = 0; b < 2; b++) begin
                r_evt[b] <= 1'b0;
                if (r_sync2[b] != r_db[b]) begin
                    if (r_cnt[b] == DB_LAST) begin
                        r_db[b]  <= r_sync2[b];
                        r_cnt[b] <= '0;
                        r_evt[b] <= ~r_sync2[b];
                    end else begin
                        r_cnt[b] <= r_cnt[b] + 1'b1;
                    end
                end else begin
                    r_cnt[b] <= '0;
                end
            end
        end
    end

    assign w_start = r_evt[0];
    assign w_lap   = r_evt[1];
    // The overflow level is not acted on in the cycle right after a pulse, so start_stop is never low twice in a row.
    assign w_ovf   = bus.stopwatch_overflow & r_start_stop;

    always_ff @(posedge CLK_100Hz or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_start_stop <= 1'b1;
            r_hold       <= 1'b1;
            r_lap_count  <= '0;
            r_running    <= 1'b0;
            r_ovf        <= 1'b0;
            r_clr_n      <= 1'b1;
            r_clr_cnt    <= 1'b0;
        end else begin
            r_start_stop <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state      <= S_RUNNING;
                        r_start_stop <= 1'b0;
                        r_running    <= 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (w_ovf) begin
                        r_state      <= S_OVF;
                        r_start_stop <= 1'b0;
                        r_running    <= 1'b0;
                        r_ovf        <= 1'b1;
                    end else if (w_start) begin
                        r_state      <= S_STOPPED;
                        r_start_stop <= 1'b0;
                        r_running    <= 1'b0;
                    end else if (w_lap) begin
                        r_state <= S_LAP;
                        r_hold  <= 1'b0;
                        if (r_lap_count != LAP_MAX) r_lap_count <= r_lap_count + 1'b1;
                    end
                end
                S_LAP: begin
                    if (w_ovf) begin
                        r_state      <= S_OVF;
                        r_start_stop <= 1'b0;
                        r_hold       <= 1'b1;
                        r_running    <= 1'b0;
                        r_ovf        <= 1'b1;
                    end else if (w_start) begin
                        r_state      <= S_STOPPED;
                        r_start_stop <= 1'b0;
                        r_hold       <= 1'b1;
                        r_running    <= 1'b0;
                    end else if (w_lap) begin
                        r_state <= S_RUNNING;
                        r_hold  <= 1'b1;
                    end
                end
                S_STOPPED: begin
                    if (w_start) begin
                        r_state      <= S_RUNNING;
                        r_start_stop <= 1'b0;
                        r_running    <= 1'b1;
                    end else if (w_lap) begin
                        r_state     <= S_CLEAR;
                        r_clr_n     <= 1'b0;
                        r_clr_cnt   <= 1'b0;
                        r_lap_count <= '0;
                        r_hold      <= 1'b1;
                    end
                end
                S_OVF: begin
                    if (w_lap) begin
                        r_state     <= S_CLEAR;
                        r_clr_n     <= 1'b0;
                        r_clr_cnt   <= 1'b0;
                        r_lap_count <= '0;
                        r_hold      <= 1'b1;
                        r_ovf       <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt) begin
                        r_state <= S_IDLE;
                        r_clr_n <= 1'b1;
                    end else begin
                        r_clr_cnt <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sw_start_stop = r_start_stop;
    assign bus.sw_hold       = r_hold;
    assign bus.sw_reset_n    = reset_n & r_clr_n;
    assign bus.running       = r_running;
    assign bus.lap_count     = r_lap_count;
    assign bus.ovf_flag      = r_ovf;
endmodule
